// File: rtl/rmw_counter_arbiter.sv
// Shared 8x32 counter memory with single-cycle read-modify-write.
// Two requesters are round-robin arbitrated. Memory is zero-filled after reset or clear.
module rmw_counter_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_clear,
    input  logic        io_req0_valid,
    output logic        io_req0_ready,
    input  logic [2:0]  io_req0_addr,
    input  logic [31:0] io_req0_inc,
    input  logic        io_req1_valid,
    output logic        io_req1_ready,
    input  logic [2:0]  io_req1_addr,
    input  logic [31:0] io_req1_inc,
    output logic        io_resp_valid,
    output logic        io_resp_id,
    output logic [2:0]  io_resp_addr,
    output logic [31:0] io_resp_data,
    output logic        io_busy
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t      r_state;
    logic [2:0]  r_idx;
    logic        r_prio;
    logic [31:0] r_mem [8];
    logic        r_resp_valid;
    logic        r_resp_id;
    logic [2:0]  r_resp_addr;
    logic [31:0] r_resp_data;

    logic        w_run;
    logic        w_go0;
    logic        w_go1;
    logic        w_sel;
    logic [2:0]  w_addr;
    logic [31:0] w_inc;
    logic [31:0] w_sum;

    // A requester may go when the other is idle or it holds priority;
    // the two readies are therefore never both granted on contention.
    assign w_run         = (r_state == ST_RUN);
    assign io_req0_ready = w_run && !io_clear && (!io_req1_valid || !r_prio);
    assign io_req1_ready = w_run && !io_clear && (!io_req0_valid ||  r_prio);

    assign w_go0  = io_req0_valid && io_req0_ready;
    assign w_go1  = io_req1_valid && io_req1_ready;
    assign w_sel  = w_go1;
    assign w_addr = w_sel ? io_req1_addr : io_req0_addr;
    assign w_inc  = w_sel ? io_req1_inc  : io_req0_inc;
    assign w_sum  = r_mem[w_addr] + w_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_idx        <= 3'd0;
            r_prio       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_addr  <= 3'd0;
            r_resp_data  <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_mem[r_idx] <= 32'd0;
                    r_idx        <= r_idx + 3'd1;
                    if (r_idx == 3'd7)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (io_clear) begin
                        r_state <= ST_INIT;
                        r_idx   <= 3'd0;
                    end else if (w_go0 || w_go1) begin
                        r_mem[w_addr] <= w_sum;
                        r_prio        <= !w_sel;
                        r_resp_valid  <= 1'b1;
                        r_resp_id     <= w_sel;
                        r_resp_addr   <= w_addr;
                        r_resp_data   <= w_sum;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign io_resp_valid = r_resp_valid;
    assign io_resp_id    = r_resp_id;
    assign io_resp_addr  = r_resp_addr;
    assign io_resp_data  = r_resp_data;
    assign io_busy       = (r_state == ST_INIT);

endmodule

// File: tb/tb_rmw_counter_arbiter.sv
// Directed table-driven bench for rmw_counter_arbiter with hand-written
// sequences for zero-fill timing, clear and mid-operation reset.
module tb_rmw_counter_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_clear;
    logic        io_req0_valid, io_req1_valid;
    logic        io_req0_ready, io_req1_ready;
    logic [2:0]  io_req0_addr, io_req1_addr;
    logic [31:0] io_req0_inc, io_req1_inc;
    logic        io_resp_valid, io_resp_id;
    logic [2:0]  io_resp_addr;
    logic [31:0] io_resp_data;
    logic        io_busy;

    rmw_counter_arbiter dut (
        .clk(clk), .reset(reset), .io_clear(io_clear),
        .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready),
        .io_req0_addr(io_req0_addr), .io_req0_inc(io_req0_inc),
        .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready),
        .io_req1_addr(io_req1_addr), .io_req1_inc(io_req1_inc),
        .io_resp_valid(io_resp_valid), .io_resp_id(io_resp_id),
        .io_resp_addr(io_resp_addr), .io_resp_data(io_resp_data),
        .io_busy(io_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        v0;
        logic [2:0]  a0;
        logic [31:0] i0;
        logic        v1;
        logic [2:0]  a1;
        logic [31:0] i1;
        logic        er0;
        logic        er1;
        logic        evld;
        logic        eid;
        logic [2:0]  eaddr;
        logic [31:0] edata;
    } vec_t;

    int    n_pass = 0;
    int    n_tot  = 0;
    string tag;

    function automatic vec_t mk(logic clr, logic v0, logic [2:0] a0, logic [31:0] i0,
                                logic v1, logic [2:0] a1, logic [31:0] i1,
                                logic er0, logic er1, logic evld, logic eid,
                                logic [2:0] eaddr, logic [31:0] edata);
        vec_t v;
        v.clr = clr; v.v0 = v0; v.a0 = a0; v.i0 = i0;
        v.v1 = v1; v.a1 = a1; v.i1 = i1;
        v.er0 = er0; v.er1 = er1; v.evld = evld; v.eid = eid;
        v.eaddr = eaddr; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        io_clear      = v.clr;
        io_req0_valid = v.v0; io_req0_addr = v.a0; io_req0_inc = v.i0;
        io_req1_valid = v.v1; io_req1_addr = v.a1; io_req1_inc = v.i1;
    endtask

    // Entered just after a negedge; leaves at the next negedge.
    task automatic step(input vec_t v);
        drive(v);
        #1;
        chk("ready0", {31'd0, io_req0_ready}, {31'd0, v.er0});
        chk("ready1", {31'd0, io_req1_ready}, {31'd0, v.er1});
        chk("busy",   {31'd0, io_busy}, 32'd0);
        @(posedge clk); #1;
        chk("resp_valid", {31'd0, io_resp_valid}, {31'd0, v.evld});
        chk("resp_id",    {31'd0, io_resp_id},    {31'd0, v.eid});
        chk("resp_addr",  {29'd0, io_resp_addr},  {29'd0, v.eaddr});
        chk("resp_data",  io_resp_data, v.edata);
        @(negedge clk);
    endtask

    // Counts consecutive busy cycles sampled at negedges; bounded.
    task automatic count_busy(input int exp);
        int cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!io_busy) break;
            cnt++;
            @(negedge clk); #1;
        end
        chk("busy_cycles", cnt, exp);
        chk("ready0_after_init", {31'd0, io_req0_ready}, 32'd1);
    endtask

    vec_t idle;
    vec_t tbl [13];

    initial begin
        idle = mk(0, 0,0,0, 0,0,0, 0,0,0,0,0,0);
        // After INIT all entries are zero and prio is 0.
        tbl[0]  = mk(0, 1,3,5,            0,0,0,   1,0, 1,0,3,32'd5);
        tbl[1]  = mk(0, 1,2,1,            0,0,0,   1,1, 1,0,2,32'd1);
        tbl[2]  = mk(0, 1,2,1,            0,0,0,   1,1, 1,0,2,32'd2);
        tbl[3]  = mk(0, 1,2,1,            0,0,0,   1,1, 1,0,2,32'd3);
        tbl[4]  = mk(0, 1,2,1,            0,0,0,   1,1, 1,0,2,32'd4);
        tbl[5]  = mk(0, 0,0,0,            1,4,7,   0,1, 1,1,4,32'd7);
        tbl[6]  = mk(0, 1,1,10,           1,1,100, 1,0, 1,0,1,32'd10);
        tbl[7]  = mk(0, 1,1,10,           1,1,100, 0,1, 1,1,1,32'd110);
        tbl[8]  = mk(0, 1,1,10,           1,1,100, 1,0, 1,0,1,32'd120);
        tbl[9]  = mk(0, 1,1,10,           1,1,100, 0,1, 1,1,1,32'd220);
        tbl[10] = mk(0, 1,7,32'hFFFFFFFF, 0,0,0,   1,0, 1,0,7,32'hFFFFFFFF);
        tbl[11] = mk(0, 1,7,2,            0,0,0,   1,1, 1,0,7,32'd1);
        tbl[12] = mk(0, 0,0,0,            0,0,0,   1,1, 0,0,7,32'd1);

        // Reset state, with requests asserted to show readies stay low.
        tag = "reset";
        reset = 1'b1;
        drive(mk(0, 1,0,1, 1,0,1, 0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        chk("resp_valid", {31'd0, io_resp_valid}, 32'd0);
        chk("resp_id",    {31'd0, io_resp_id},    32'd0);
        chk("resp_addr",  {29'd0, io_resp_addr},  32'd0);
        chk("resp_data",  io_resp_data, 32'd0);
        chk("busy",       {31'd0, io_busy}, 32'd1);
        chk("ready0",     {31'd0, io_req0_ready}, 32'd0);
        chk("ready1",     {31'd0, io_req1_ready}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        drive(idle);
        #1;
        tag = "init";
        count_busy(8);

        for (int i = 0; i < 13; i++) begin
            tag = $sformatf("vec%0d", i);
            step(tbl[i]);
        end

        // Clear while req1 is waiting: nothing transfers, INIT reruns.
        tag = "clear";
        drive(mk(1, 0,0,0, 1,2,9, 0,0,0,0,0,0));
        #1;
        chk("ready0", {31'd0, io_req0_ready}, 32'd0);
        chk("ready1", {31'd0, io_req1_ready}, 32'd0);
        @(posedge clk); #1;
        chk("resp_valid", {31'd0, io_resp_valid}, 32'd0);
        chk("busy",       {31'd0, io_busy}, 32'd1);
        @(negedge clk);
        drive(idle);
        #1;
        count_busy(8);
        tag = "post_clear";
        step(mk(0, 0,0,0, 1,2,9,  0,1, 1,1,2,32'd9));
        step(mk(0, 1,6,8, 0,0,0,  1,0, 1,0,6,32'd8));

        // Reset asserted during a transfer cycle.
        tag = "mid_reset";
        reset = 1'b1;
        drive(mk(0, 1,6,8, 0,0,0, 0,0,0,0,0,0));
        @(posedge clk); #1;
        chk("resp_valid", {31'd0, io_resp_valid}, 32'd0);
        chk("resp_data",  io_resp_data, 32'd0);
        chk("busy",       {31'd0, io_busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(idle);
        #1;
        count_busy(8);
        tag = "post_reset";
        step(mk(0, 1,0,10, 1,0,100, 1,0, 1,0,0,32'd10));
        step(mk(0, 1,0,10, 1,0,100, 0,1, 1,1,0,32'd110));
        step(mk(0, 1,6,1,  0,0,0,   1,0, 1,0,6,32'd1));
        tag = "tail";
        step(mk(0, 0,0,0, 0,0,0, 1,1, 0,0,6,32'd1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/rmw_counter_arbiter.md
# rmw_counter_arbiter

Shared 8-entry × 32-bit counter memory with read-modify-write update, arbitrated between two requesters. Each accepted request adds a 32-bit increment to one entry in a single cycle: combinational read, write at the clock edge. A registered response carries the updated value. The block owns the memory; it zero-fills it after reset or on a clear command, and round-robins access between requester 0 and requester 1.

## Interface
- No parameters: depth 8, data width 32, address width 3, all fixed.
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- io_clear  in  1  request to zero-fill the memory; sampled only in RUN.
- io_req0_valid  in  1  requester 0 has a request.
- io_req0_ready  out  1  requester 0 transfer allowed this cycle.
- io_req0_addr  in  3  entry index for requester 0.
- io_req0_inc  in  32  increment for requester 0.
- io_req1_valid / io_req1_ready / io_req1_addr / io_req1_inc  same widths and meanings, requester 1.
- io_resp_valid  out  1  one-cycle pulse, one per accepted request.
- io_resp_id  out  1  requester that was served (0/1).
- io_resp_addr  out  3  entry that was updated.
- io_resp_data  out  32  value written (old + inc).
- io_busy  out  1  high while in INIT (zero-fill).

## Operation
- States: INIT, RUN. Reset forces INIT with fill index 0 and prio 0.
- INIT behaviour:
  - Each edge with reset low writes mem[idx] = 0 and increments idx.
  - The edge that writes idx 7 moves the block to RUN and wraps idx to 0.
  - Both readies are 0; io_busy is 1.
- RUN, readiness:
  - io_req0_ready = !io_clear && (!io_req1_valid || prio == 0).
  - io_req1_ready = !io_clear && (!io_req0_valid || prio == 1).
  - Readies do not depend on the requester's own valid.
- Transfer: a request transfers when valid && ready, at most one per cycle.
  - The winner's entry is read combinationally.
  - sum = mem[addr] + inc, mod 2^32; carry discarded.
  - mem[addr] <= sum at the edge.
- Priority: after a transfer from requester k, prio <= !k. With no transfer, prio holds.
- io_clear in RUN: no transfer that cycle; next state INIT, idx 0. prio is unchanged.
- Response register: loaded on each transfer edge with id, addr and sum, and io_resp_valid = 1. Otherwise io_resp_valid = 0 and id/addr/data hold.
- No response backpressure: the consumer must take every pulse.
- Back-to-back same-address updates: no hazard. The write lands at the edge and the next cycle's read sees it; no forwarding required.
- Reset values:
  - State INIT, idx 0, prio 0.
  - io_resp_valid 0, io_resp_id 0, io_resp_addr 0, io_resp_data 0.
  - io_busy 1, both readies 0.
  - Memory contents are undefined until INIT completes.

## Timing
- After reset deasserts (first edge E0 with reset low), INIT writes entries at E0..E7. RUN, readies and io_busy=0 take effect from the cycle after E7.
- Request latency: transfer in cycle N; io_resp_valid is high in cycle N+1 only.
- Throughput: one update per cycle. With both valid continuously, grants alternate every cycle.
- io_clear high in cycle N: io_busy high from N+1 for 8 cycles; first possible transfer in N+9.
- Reset mid-operation:
  - The update in the reset cycle is not performed.
  - io_resp_valid is 0 the next cycle.
  - Any pending response pulse is dropped.
  - INIT restarts.

## Test plan
- Zero-fill after reset: release reset, then a single req0 to addr 3 with inc 5 in the first ready cycle. Required: io_busy high for exactly 8 cycles; response id 0, addr 3, data 5 one cycle after transfer.
- Back-to-back same address: req0 to addr 2 with inc 1 for 4 consecutive cycles. Required: io_resp_data 1, 2, 3, 4 on consecutive cycles, with no stalls.
- Contention: both valid every cycle; req0 addr 1 inc 10, req1 addr 1 inc 100. Required:
  - Grants alternate 0,1,0,1, with req0 first after reset.
  - Response data 10, 110, 120, 220.
- Wrap-around: mem[7] raised to 0xFFFFFFFF via inc 0xFFFFFFFF, then inc 2. Required: io_resp_data 0x00000001.
- Clear: io_clear pulsed in RUN while req1 is valid. Required:
  - req1_ready low that cycle; io_busy high for 8 cycles.
  - req1 to the previously incremented addr then returns its own inc as data.
- Reset mid-operation: assert reset in a transfer cycle. Required:
  - io_resp_valid 0 in the following cycle.
  - INIT restarts.
  - The entry reads 0 after INIT.
